// File: rtl/noc_pkg.sv
// Shared router types and helpers: arbitration FSM states, default port-field
// width and a one-hot encoder.
`default_nettype none

package noc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int PORTW_DEF = 3;

  // Up to 32 ports; callers cast the result down to their own port count.
  function automatic logic [31:0] onehot(input int idx, input int nport);
    logic [31:0] v;
    v = '0;
    if (idx >= 0 && idx < nport && idx < 32) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb.sv
// Combinational rotating-priority arbiter: the first set request at or above
// ptr, wrapping modulo N, wins.
`default_nettype none

module rr_arb #(
  parameter  int N  = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grt,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic found;
    int   pos;
    grt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        grt[pos] = 1'b1;
        idx      = PW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muxcont_rr.sv
// Output-port mux controller: rotating-priority arbitration with wormhole
// locking, downstream credit gating and a registered crossbar select.
`default_nettype none

module muxcont_rr
  import noc_pkg::*;
#(
  parameter int NPORT   = 5,
  parameter int PORTW   = PORTW_DEF,
  parameter int PORTID  = 0,
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT*PORTW-1:0] dst,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT-1:0]       tail,
  input  logic                   credit_in,
  output logic [NPORT-1:0]       grt,
  output logic [NPORT-1:0]       sel,
  output logic                   out_vld,
  output logic                   credit_err
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic             err_q, err_d;
  logic [NPORT-1:0] sel_q;
  logic             vld_q;

  logic [NPORT-1:0] m;
  logic [NPORT-1:0] arb_grt;
  logic [PW-1:0]    arb_idx;
  logic [NPORT-1:0] owner_oh;
  logic             xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (int'(v) == NPORT - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    m = '0;
    for (int i = 0; i < NPORT; i++)
      m[i] = req[i] && (dst[i*PORTW +: PORTW] == PORTW'(PORTID));
  end

  rr_arb #(.N(NPORT)) u_arb (
    .req (m),
    .ptr (ptr_q),
    .grt (arb_grt),
    .idx (arb_idx)
  );

  assign owner_oh = NPORT'(onehot(int'(owner_q), NPORT));

  // Grants are suppressed while reset is held so an aborted packet cannot
  // slip a flit through before the FSM is released.
  always_comb begin
    grt = '0;
    if (rst_ && credit_q != '0) begin
      if (state_q == IDLE)   grt = arb_grt;
      else if (m[owner_q])   grt = owner_oh;
    end
  end

  assign xfer = |grt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (tail[arb_idx]) begin
            ptr_d = wrap_inc(arb_idx);
          end else begin
            state_d = LOCK;
            owner_d = arb_idx;
          end
        end
      end
      LOCK: begin
        if (xfer && tail[owner_q]) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (xfer && !credit_in) begin
      credit_d = credit_q - 1'b1;
    end else if (credit_in && !xfer) begin
      if (credit_q == CW'(CREDITS)) err_d    = 1'b1;
      else                          credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= CW'(CREDITS);
      err_q    <= 1'b0;
      sel_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      sel_q    <= grt;
      vld_q    <= xfer;
    end
  end

  assign sel        = sel_q;
  assign out_vld    = vld_q;
  assign credit_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_muxcont_rr.sv
// Bench for muxcont_rr: a default instance checked against a packet-level
// reference model, plus an 8-port / PORTID 6 / 2-credit instance with directed expectations.
`default_nettype none

module tb_muxcont_rr;

  logic        clk;
  logic        rst_;

  logic [14:0] dst_a;
  logic [4:0]  req_a, tail_a, grt_a, sel_a;
  logic        cin_a, vld_a, err_a;

  logic [23:0] dst_b;
  logic [7:0]  req_b, tail_b, grt_b, sel_b;
  logic        cin_b, vld_b, err_b;

  int errors = 0;
  int checks = 0;

  // reference model state for instance A (5 ports, PORTID 0, 4 credits)
  int mdl_ptr, mdl_owner, mdl_credit;
  bit mdl_lock, mdl_err;

  muxcont_rr #(.NPORT(5), .PORTW(3), .PORTID(0), .CREDITS(4)) dut_a (
    .clk(clk), .rst_(rst_), .dst(dst_a), .req(req_a), .tail(tail_a),
    .credit_in(cin_a), .grt(grt_a), .sel(sel_a), .out_vld(vld_a),
    .credit_err(err_a)
  );

  muxcont_rr #(.NPORT(8), .PORTW(3), .PORTID(6), .CREDITS(2)) dut_b (
    .clk(clk), .rst_(rst_), .dst(dst_b), .req(req_b), .tail(tail_b),
    .credit_in(cin_b), .grt(grt_b), .sel(sel_b), .out_vld(vld_b),
    .credit_err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_grt(input logic [4:0] m);
    logic [4:0] g;
    g = '0;
    if (mdl_credit > 0) begin
      if (mdl_lock) begin
        if (m[mdl_owner]) g[mdl_owner] = 1'b1;
      end else begin
        for (int k = 0; k < 5; k++) begin
          int p;
          p = (mdl_ptr + k) % 5;
          if (g == '0 && m[p]) g[p] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    mdl_ptr = 0; mdl_owner = 0; mdl_credit = 4; mdl_lock = 0; mdl_err = 0;
  endtask

  task automatic model_update(input logic [4:0] g, input logic [4:0] t, input logic cin);
    int w;
    w = 0;
    for (int i = 0; i < 5; i++) if (g[i]) w = i;
    if (!mdl_lock) begin
      if (g != '0) begin
        if (t[w]) mdl_ptr = (w + 1) % 5;
        else begin mdl_lock = 1; mdl_owner = w; end
      end
    end else if (g != '0 && t[mdl_owner]) begin
      mdl_lock = 0;
      mdl_ptr  = (mdl_owner + 1) % 5;
    end
    if (g != '0 && !cin)       mdl_credit--;
    else if (cin && g == '0) begin
      if (mdl_credit == 4) mdl_err = 1;
      else                 mdl_credit++;
    end
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic step_a(input logic [4:0] r, input logic [4:0] mm,
                        input logic [4:0] t, input logic cin);
    logic [4:0] exp;
    req_a = r; tail_a = t; cin_a = cin;
    for (int i = 0; i < 5; i++)
      dst_a[i*3 +: 3] = mm[i] ? 3'd0 : 3'($urandom_range(1, 7));
    exp = model_grt(r & mm);
    #2;
    chk("grt_a", grt_a, exp);
    @(posedge clk);
    model_update(exp, t, cin);
    #1;
    chk("sel_a", sel_a, exp);
    chk("vld_a", vld_a, |exp);
    chk("err_a", err_a, mdl_err);
  endtask

  task automatic step_b(input logic [7:0] r, input logic [2:0] dv,
                        input logic cin, input logic [7:0] exp);
    req_b = r; tail_b = '1; cin_b = cin;
    for (int i = 0; i < 8; i++) dst_b[i*3 +: 3] = dv;
    #2;
    chk("grt_b", grt_b, exp);
    @(posedge clk);
    #1;
    chk("sel_b", sel_b, exp);
    chk("vld_b", vld_b, |exp);
  endtask

  task automatic do_reset();
    #2 rst_ = 1'b0;
    #1;
    chk("rst_grt_a", grt_a, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_vld_a", vld_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_sel_b", sel_b, 0);
    chk("rst_vld_b", vld_b, 0);
    model_reset();
    req_a = '0; cin_a = 1'b0; req_b = '0; cin_b = 1'b0;
    @(posedge clk);
    #4 rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ = 1'b0;
    dst_a = '0; req_a = '0; tail_a = '0; cin_a = 1'b0;
    dst_b = '0; req_b = '0; tail_b = '0; cin_b = 1'b0;
    model_reset();
    @(posedge clk);
    #4 rst_ = 1'b1;
    @(posedge clk);
    #1;
    chk("init_sel_a", sel_a, 0);
    chk("init_vld_a", vld_a, 0);
    chk("init_err_a", err_a, 0);
    chk("init_grt_a", grt_a, 0);

    // 8-port instance: non-matching traffic, then credit-limited ports 5 and 7
    step_b(8'hFF,        3'd3, 1'b0, 8'h00);
    step_b(8'b1010_0000, 3'd6, 1'b0, 8'b0010_0000);
    step_b(8'b1010_0000, 3'd6, 1'b0, 8'b1000_0000);
    step_b(8'b1010_0000, 3'd6, 1'b0, 8'h00);
    step_b(8'h00,        3'd6, 1'b1, 8'h00);
    step_b(8'b1010_0000, 3'd6, 1'b0, 8'b0010_0000);
    step_b(8'b1010_0000, 3'd6, 1'b0, 8'h00);
    chk("err_b", err_b, 0);

    // ports 1 and 2 alternate until credits run out
    do_reset();
    repeat (5) step_a(5'b00110, 5'b11111, 5'b11111, 1'b0);
    step_a(5'b00000, 5'b11111, 5'b11111, 1'b1);
    step_a(5'b00110, 5'b11111, 5'b11111, 1'b1);
    step_a(5'b00110, 5'b11111, 5'b11111, 1'b0);
    step_a(5'b00110, 5'b11111, 5'b11111, 1'b0);
    // refill beyond capacity: sticky credit_err
    repeat (5) step_a(5'b00000, 5'b11111, 5'b11111, 1'b1);
    step_a(5'b00000, 5'b11111, 5'b11111, 1'b0);

    // port 3 wormhole with a bubble while port 0 waits
    do_reset();
    step_a(5'b01000, 5'b11111, 5'b00000, 1'b1);
    step_a(5'b01001, 5'b11111, 5'b00000, 1'b1);
    step_a(5'b00001, 5'b11111, 5'b00000, 1'b1);
    step_a(5'b01001, 5'b11111, 5'b00000, 1'b1);
    step_a(5'b01001, 5'b11111, 5'b01000, 1'b1);
    step_a(5'b01001, 5'b11111, 5'b00001, 1'b1);
    // non-matching destinations
    step_a(5'b11111, 5'b00000, 5'b11111, 1'b0);

    // reset while port 3 holds the lock
    step_a(5'b01000, 5'b11111, 5'b00000, 1'b0);
    step_a(5'b01000, 5'b11111, 5'b00000, 1'b0);
    req_a = 5'b01000;
    do_reset();
    step_a(5'b11010, 5'b11111, 5'b11111, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r, mm, t;
      logic       c;
      r  = 5'($urandom);
      mm = 5'($urandom) | 5'($urandom);
      t  = 5'($urandom);
      c  = ($urandom_range(0, 2) == 0);
      step_a(r, mm, t, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muxcont_rr.md
# muxcont_rr

Parametrised output-port mux controller for the router crossbar, successor to the fixed five-port controller. It selects which of NPORT input ports drives output port PORTID, using rotating-priority arbitration and wormhole locking that holds a grant from head flit to tail flit. It also gates grants on a downstream credit counter. It emits a one-hot grant to the input ports and a registered one-hot select to the crossbar data mux.

## Interface
Parameters:
- NPORT, 5, number of input ports competing for this output
- PORTW, 3, width of a destination-port field
- PORTID, 0, output-port index this instance controls
- CREDITS, 4, downstream buffer depth; initial and maximum credit count

Ports:
- clk  in  1  clock; all state on rising edge
- rst_  in  1  reset; asynchronous, active-low
- dst  in  NPORT*PORTW  packed destination fields; port i at bits [i*PORTW +: PORTW]
- req  in  NPORT  flit-valid per input port
- tail  in  NPORT  flit on port i is the last of its packet; single-flit packet = head with tail=1
- credit_in  in  1  downstream returned one buffer slot this cycle
- grt  out  NPORT  combinational one-hot grant; flit on port i transfers this cycle iff grt[i]
- sel  out  NPORT  registered copy of grt; drives crossbar mux one cycle later
- out_vld  out  1  registered |grt; qualifies crossbar output with sel
- credit_err  out  1  sticky; set by credit_in while count is already CREDITS

## Operation
- Match: m[i] = req[i] & (dst_i == PORTID).
- Credit gate: no grant of any kind while credit_cnt == 0.
- Transfer: a transfer is any cycle with |grt. It decrements credit_cnt.
  - credit_in alone increments credit_cnt.
  - Transfer and credit_in in the same cycle leave credit_cnt unchanged.
  - credit_in at CREDITS with no transfer: count saturates and credit_err is set. Only reset clears credit_err.
- State machine, two states:
  - IDLE: grt = rotating-priority pick of m, searching from ptr upward with wrap modulo NPORT.
    - Winner w with tail[w]=1: stay IDLE; ptr <= (w+1) mod NPORT.
    - Winner w with tail[w]=0: go to LOCK; owner <= w.
    - No winner: ptr and state are unchanged.
  - LOCK: grt = onehot(owner) only when m[owner] is true. Other ports are ignored even if owner is idle.
    - Transfer with tail[owner]=1: go to IDLE; ptr <= (owner+1) mod NPORT.
    - Owner deasserting req (bubble) keeps LOCK indefinitely.
- sel <= grt and out_vld <= |grt every cycle.
- Reset values: state IDLE, ptr 0, owner 0, credit_cnt CREDITS, sel 0, out_vld 0, credit_err 0. grt is 0 whenever m is 0.
- Reset asserted mid-packet: the lock is dropped immediately and asynchronously. No flit of the aborted packet is granted after release.

## Timing
- Grant latency 0: grt is combinational from req/dst/tail/state/credit_cnt in the same cycle.
- Select latency 1: sel and out_vld follow grt by exactly one clock.
- Credit returned in cycle t is usable for a grant in cycle t+1.
- Credit-limited back-to-back throughput is one flit per cycle while credit_cnt > 0.
- Arbitration fairness: any persistently matching port is granted within NPORT-1 packets of other ports.
- credit_cnt width: $clog2(CREDITS+1). ptr and owner width: $clog2(NPORT).

## Structure
- Shared package noc_pkg holds:
  - the state enum {IDLE, LOCK}
  - the PORTW default
  - a function onehot(idx, NPORT)
- Sub-module rr_arb (parameter N):
  - inputs: req[N], ptr
  - outputs: one-hot grt[N] and encoded winner idx
  - purely combinational
- muxcont_rr holds the FSM, ptr, owner, credit counter and output registers.

## Test plan
- Reset, then m=00110, ptr=0, all tail=1, credits 4 → grants port1, then port2, then port1; sel/out_vld lag one cycle; credit_cnt reaches 1.
- Port 3 sends 4-flit packet (tail on flit 4) while port 0 requests continuously → grt=01000 for 4 transfer cycles, then 00001; bubbles on port 3 inside packet keep port 0 blocked.
- CREDITS=2, no credit_in, three single-flit requests → two grants then grt=0; one credit_in pulse → exactly one more grant on the next cycle.
- Transfer with simultaneous credit_in at credit_cnt=1 → count stays 1; credit_in at credit_cnt=CREDITS → credit_err=1 and stays 1.
- Requests with dst≠PORTID on all ports → grt=0, ptr unchanged; NPORT=8, PORTID=6 instance repeats the first scenario with ports 5 and 7.
- rst_ pulled low asynchronously mid-packet in LOCK → sel=0, out_vld=0, credit_cnt=CREDITS immediately; after release, lowest-index requester from ptr 0 wins.
